ptp_tx_axis_arb: RTL and testbench
==================================

Name: ptp_tx_axis_arb

Overview:
- Two-input, frame-atomic AXI-Stream arbiter for 8-bit UDP payload streams. It sits between the payload sources and the single payload input of the UDP/GMII transmit path.
- Input 0 carries PTP message payload from the PTP generator. Input 1 carries timestamp-service (TSS) payload from the TSS TX controller.
- A grant is held from the first byte of a frame through its tlast, so frames never interleave.
- Over-length frames are truncated and flagged.
- Output is registered through a skid buffer for full throughput and timing isolation.

Parameters:
- DATA_WIDTH, 8, tdata width in bits. Only 8 is supported.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority with input 0 highest.
- MAX_LEN, 1500, maximum payload bytes per frame (at least 2).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock for all logic (GMII TX clock domain)
- rst  in  1  synchronous, active-high reset
- s0_axis_tdata  in  8  input 0 (PTP) data
- s0_axis_tvalid  in  1  input 0 valid
- s0_axis_tready  out  1  input 0 ready
- s0_axis_tlast  in  1  input 0 end of frame
- s1_axis_tdata / s1_axis_tvalid / s1_axis_tready / s1_axis_tlast  as s0, for input 1 (TSS)
- m_axis_tdata  out  8  output data
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output end of frame
- m_axis_tid  out  1  source index of the current byte
- m_axis_tuser  out  1  asserted with tlast on a truncated frame
- frame_cnt0_o  out  CNT_WIDTH  frames completed from input 0
- frame_cnt1_o  out  CNT_WIDTH  frames completed from input 1
- trunc_cnt_o  out  CNT_WIDTH  frames truncated, both inputs combined

Behaviour:
- **Reset values:** m_axis_tvalid=0, tdata/tlast/tid/tuser=0, s0/s1_tready=0, all counters 0, FSM=IDLE, byte count 0, last_grant=1 (so input 0 wins the first round-robin tie).
- **Reset mid-frame:** aborts immediately; skid contents are discarded. The downstream sees a frame without tlast, and the UDP TX is reset by the same rst.
- **FSM states:** IDLE, PASS, DRAIN.
- **IDLE:**
  - Both tready are 0.
  - If any tvalid is high, register the grant and move to PASS. Grant decision:
    - ARB_MODE=1: input 0 wins if valid.
    - ARB_MODE=0: on a tie, the input not equal to last_grant wins; otherwise the single valid input wins.
  - last_grant updates at the moment of grant.
  - Decision to first-byte-accepted latency is 1 cycle. No bytes are accepted in the IDLE cycle.
- **PASS:**
  - Granted tready = skid in_ready. Ungranted tready = 0.
  - Each handshake writes {tdata, tlast_out, tid=grant, tuser} into the skid and increments the byte count (width $clog2(MAX_LEN+1)).
  - Handshake with tlast=1: tlast_out=1, tuser=0, increment frame_cntN (wrapping), clear the count, go to IDLE.
  - Handshake with tlast=0 and count==MAX_LEN-1 (the MAX_LEN-th byte): tlast_out=1, tuser=1, increment trunc_cnt (the frame counter is not incremented), go to DRAIN.
  - tlast=1 exactly on the MAX_LEN-th byte is a normal frame, not truncated.
- **DRAIN:** granted tready=1 and bytes are discarded. On a tlast handshake go to IDLE. Nothing is written to the skid.
- **Back-to-back frames:** min 1 idle cycle between frames on the input side (IDLE re-arbitration cycle).
- **Skid buffer:** 2 entries.
  - in_ready = entry 1 empty, registered.
  - Output comes from entry 0. Input handshake to m_axis_tvalid latency is 1 cycle.
  - Sustains 1 byte/cycle with m_axis_tready held high.
  - m_axis_* fields must be stable while tvalid=1 and tready=0.
- **Counters:** saturate never, wrap modulo 2^CNT_WIDTH.
- **tdata preservation:** no byte reordering or modification except forced tlast/tuser.

Decomposition:
- Shared package ptp_axis_pkg:
  - arb_state_e enum (IDLE, PASS, DRAIN)
  - ARB_RR / ARB_FIXED localparams
  - axis8_beat_t packed struct {tdata[7:0], tlast, tid, tuser}
- Sub-module axis_skid_buf: 2-entry registered skid carrying axis8_beat_t, with the same clk/rst.

Test Plan:
- **Single frame:** s0 sends 4 bytes 0xA1..0xA4 (tlast on 0xA4), m_tready=1 → 4 beats out, tid=0, tlast on 0xA4, tuser=0, frame_cnt0_o=1, first output beat 2 cycles after s0_tvalid rises.
- **Round-robin:** ARB_MODE=0, s0 and s1 both hold 3-byte frames continuously → output frame order 0,1,0,1, no interleaving inside a frame, s1 tready=0 throughout input-0 frames.
- **Fixed priority:** ARB_MODE=1, same stimulus → all input-0 frames are served while s0_tvalid stays high. s1 is granted only in an IDLE cycle where s0_tvalid=0.
- **Truncation:** MAX_LEN=8, s1 sends 12 bytes 0x00..0x0B → output 0x00..0x07, tlast+tuser on 0x07, bytes 0x08..0x0B accepted and dropped, trunc_cnt_o=1, frame_cnt1_o=0. A 8-byte frame with tlast on byte 8 gives tuser=0.
- **Backpressure:** m_tready pattern 1,0,0,1,0,1 over a 10-byte frame → all 10 bytes delivered in order, no duplicates, outputs stable while stalled, s0_tready deasserts within 1 cycle of skid full.
- **Reset mid-frame:** rst pulse for 1 cycle during byte 3 of a 6-byte frame → next cycle m_tvalid=0, both tready=0, counters 0. A new frame from s1 afterwards is granted normally.

Source files
------------

// File: rtl/ptp_axis_pkg.sv
// Shared types for the PTP/TSS transmit payload path.
// Contents: arbiter FSM state enum, arbitration mode constants and the
// 8-bit AXI-Stream beat carried through the output skid buffer.
package ptp_axis_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  typedef struct packed {
    logic [7:0] tdata;
    logic       tlast;
    logic       tid;
    logic       tuser;
  } axis8_beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer for axis8_beat_t.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_beat/in_valid      write side; a write happens when in_valid && in_ready
//   in_ready              high while the skid entry (entry 1) is empty
//   out_beat/out_valid    read side, driven straight from entry 0
//   out_ready             downstream ready
module axis_skid_buf
  import ptp_axis_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  axis8_beat_t in_beat,
  input  logic        in_valid,
  output logic        in_ready,
  output axis8_beat_t out_beat,
  output logic        out_valid,
  input  logic        out_ready
);

  axis8_beat_t out_q;
  axis8_beat_t skid_q;
  logic        out_valid_q;
  logic        skid_valid_q;
  logic        push;

  assign in_ready  = !skid_valid_q;
  assign push      = in_valid && !skid_valid_q;
  assign out_beat  = out_q;
  assign out_valid = out_valid_q;

  // Entry 0 refills from the skid first; a stalled entry 0 diverts writes into the skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_ready || !out_valid_q) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (push) begin
        out_q       <= in_beat;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (push) begin
      skid_q       <= in_beat;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/ptp_tx_axis_arb.sv
// Frame-atomic two-input AXI-Stream arbiter feeding the UDP/GMII TX payload input.
// Input 0 = PTP generator payload, input 1 = TSS TX controller payload.
// Ports:
//   clk, rst                      GMII TX clock, synchronous active-high reset
//   s0_axis_*, s1_axis_*          payload inputs (tdata/tvalid/tready/tlast)
//   m_axis_*                      registered output; tid = source, tuser = truncated
//   frame_cnt0_o, frame_cnt1_o    completed frames per input (wrapping)
//   trunc_cnt_o                   truncated frames, both inputs (wrapping)
module ptp_tx_axis_arb
  import ptp_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARB_MODE   = ARB_RR,
  parameter int unsigned MAX_LEN    = 1500,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic                  s0_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic                  s1_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tid,
  output logic                  m_axis_tuser,
  output logic [CNT_WIDTH-1:0]  frame_cnt0_o,
  output logic [CNT_WIDTH-1:0]  frame_cnt1_o,
  output logic [CNT_WIDTH-1:0]  trunc_cnt_o
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  arb_state_e           state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [CNT_WIDTH-1:0] fcnt0_q, fcnt0_d;
  logic [CNT_WIDTH-1:0] fcnt1_q, fcnt1_d;
  logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;

  logic                  sel_valid_c;
  logic                  sel_last_c;
  logic [DATA_WIDTH-1:0] sel_data_c;
  logic                  skid_ready_c;
  logic                  push_c;
  logic                  s0_ready_c;
  logic                  s1_ready_c;
  axis8_beat_t           beat_c;
  axis8_beat_t           out_beat_c;

  // Granted input as seen by the FSM.
  assign sel_valid_c = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_last_c  = grant_q ? s1_axis_tlast  : s0_axis_tlast;
  assign sel_data_c  = grant_q ? s1_axis_tdata  : s0_axis_tdata;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= '0;
      fcnt0_q      <= '0;
      fcnt1_q      <= '0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      fcnt0_q      <= fcnt0_d;
      fcnt1_q      <= fcnt1_d;
      tcnt_q       <= tcnt_d;
    end
  end

  // Arbitration, frame length tracking, truncation and drain.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    fcnt0_d      = fcnt0_q;
    fcnt1_d      = fcnt1_q;
    tcnt_d       = tcnt_q;
    push_c       = 1'b0;
    beat_c       = '0;
    s0_ready_c   = 1'b0;
    s1_ready_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          if (ARB_MODE == ARB_FIXED) begin
            grant_d = !s0_axis_tvalid;
          end else if (s0_axis_tvalid && s1_axis_tvalid) begin
            grant_d = !last_grant_q;
          end else begin
            grant_d = s1_axis_tvalid;
          end
          last_grant_d = grant_d;
          state_d      = PASS;
        end
      end

      PASS: begin
        s0_ready_c = !grant_q && skid_ready_c;
        s1_ready_c = grant_q && skid_ready_c;
        if (sel_valid_c && skid_ready_c) begin
          push_c       = 1'b1;
          beat_c.tdata = sel_data_c;
          beat_c.tid   = grant_q;
          if (sel_last_c) begin
            beat_c.tlast = 1'b1;
            if (grant_q) fcnt1_d = fcnt1_q + CNT_WIDTH'(1);
            else         fcnt0_d = fcnt0_q + CNT_WIDTH'(1);
            len_d   = '0;
            state_d = IDLE;
          end else if (len_q == LEN_W'(MAX_LEN - 1)) begin
            // MAX_LEN-th byte without tlast: close the frame here and discard the rest.
            beat_c.tlast = 1'b1;
            beat_c.tuser = 1'b1;
            tcnt_d       = tcnt_q + CNT_WIDTH'(1);
            len_d        = '0;
            state_d      = DRAIN;
          end else begin
            len_d = len_q + LEN_W'(1);
          end
        end
      end

      DRAIN: begin
        s0_ready_c = !grant_q;
        s1_ready_c = grant_q;
        if (sel_valid_c && sel_last_c) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  axis_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_beat   (beat_c),
    .in_valid  (push_c),
    .in_ready  (skid_ready_c),
    .out_beat  (out_beat_c),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign s0_axis_tready = s0_ready_c;
  assign s1_axis_tready = s1_ready_c;
  assign m_axis_tdata   = out_beat_c.tdata;
  assign m_axis_tlast   = out_beat_c.tlast;
  assign m_axis_tid     = out_beat_c.tid;
  assign m_axis_tuser   = out_beat_c.tuser;
  assign frame_cnt0_o   = fcnt0_q;
  assign frame_cnt1_o   = fcnt1_q;
  assign trunc_cnt_o    = tcnt_q;

endmodule

// File: tb/tb_ptp_tx_axis_arb.sv
// Directed bench for ptp_tx_axis_arb.
// Instance 0: round-robin, MAX_LEN=1500. Instance 1: fixed priority, MAX_LEN=8.
module tb_ptp_tx_axis_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic [7:0]  s_tdata  [2][2];
  logic        s_tvalid [2][2];
  logic        s_tlast  [2][2];
  logic        s_tready [2][2];
  logic [7:0]  m_tdata  [2];
  logic        m_tvalid [2];
  logic        m_tready [2];
  logic        m_tlast  [2];
  logic        m_tid    [2];
  logic        m_tuser  [2];
  logic [15:0] fc0      [2];
  logic [15:0] fc1      [2];
  logic [15:0] tc       [2];

  ptp_tx_axis_arb #(.ARB_MODE(0), .MAX_LEN(1500)) dut_a (
    .clk(clk), .rst(rst[0]),
    .s0_axis_tdata(s_tdata[0][0]), .s0_axis_tvalid(s_tvalid[0][0]),
    .s0_axis_tready(s_tready[0][0]), .s0_axis_tlast(s_tlast[0][0]),
    .s1_axis_tdata(s_tdata[0][1]), .s1_axis_tvalid(s_tvalid[0][1]),
    .s1_axis_tready(s_tready[0][1]), .s1_axis_tlast(s_tlast[0][1]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tid(m_tid[0]), .m_axis_tuser(m_tuser[0]),
    .frame_cnt0_o(fc0[0]), .frame_cnt1_o(fc1[0]), .trunc_cnt_o(tc[0])
  );

  ptp_tx_axis_arb #(.ARB_MODE(1), .MAX_LEN(8)) dut_b (
    .clk(clk), .rst(rst[1]),
    .s0_axis_tdata(s_tdata[1][0]), .s0_axis_tvalid(s_tvalid[1][0]),
    .s0_axis_tready(s_tready[1][0]), .s0_axis_tlast(s_tlast[1][0]),
    .s1_axis_tdata(s_tdata[1][1]), .s1_axis_tvalid(s_tvalid[1][1]),
    .s1_axis_tready(s_tready[1][1]), .s1_axis_tlast(s_tlast[1][1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tid(m_tid[1]), .m_axis_tuser(m_tuser[1]),
    .frame_cnt0_o(fc0[1]), .frame_cnt1_o(fc1[1]), .trunc_cnt_o(tc[1])
  );

  int          n_err = 0;
  int          n_chk = 0;
  bit          done  = 1'b0;
  logic [10:0] obs_a [$];
  logic [10:0] obs_b [$];
  logic [10:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    tick(1);
    rst[d] = 1'b0;
  endtask

  // Present n bytes base, base+1, ... on input p of instance d, tlast on the final one.
  task automatic send(input int d, input int p, input logic [7:0] base, input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_tvalid[d][p] = 1'b1;
      s_tdata[d][p]  = base + 8'(i);
      s_tlast[d][p]  = (i == n - 1);
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clk);
        ok = s_tready[d][p];
        @(posedge clk);
        #1;
      end
      if (!ok) break;
    end
    s_tvalid[d][p] = 1'b0;
    s_tlast[d][p]  = 1'b0;
    s_tdata[d][p]  = 8'h00;
    chk($sformatf("send_done d%0d p%0d", d, p), 32'(ok), 32'd1);
  endtask

  // Expected output beats {tid, tuser, tlast, tdata} for an n-byte frame under length limit keep.
  task automatic add_frame(input logic id, input logic [7:0] base, input int n, input int keep);
    logic       u;
    logic       l;
    logic [7:0] b;
    for (int i = 0; i < n && i < keep; i++) begin
      u = (n > keep) && (i == keep - 1);
      l = (i == n - 1) || (i == keep - 1);
      b = base + 8'(i);
      exp_q.push_back({id, u, l, b});
    end
  endtask

  task automatic cmp_frames(input string tag, input int d, input int mark);
    int          n_obs;
    logic [10:0] o;
    n_obs = ((d == 0) ? obs_a.size() : obs_b.size()) - mark;
    chk({tag, " beats"}, 32'(n_obs), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
      o = (d == 0) ? obs_a[mark + i] : obs_b[mark + i];
      chk($sformatf("%s beat%0d", tag, i), 32'(o), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    int          mark;
    bit   [5:0]  pat;
    logic [11:0] held  [2];
    bit          stall [2];
    bit          fill;

    for (int d = 0; d < 2; d++) begin
      rst[d]      = 1'b1;
      m_tready[d] = 1'b1;
      held[d]     = '0;
      stall[d]    = 1'b0;
      for (int p = 0; p < 2; p++) begin
        s_tdata[d][p]  = 8'h00;
        s_tvalid[d][p] = 1'b0;
        s_tlast[d][p]  = 1'b0;
      end
    end
    fill = 1'b0;

    fork
      // Output monitor and per-cycle invariants.
      begin
        while (!done) begin
          @(negedge clk);
          for (int d = 0; d < 2; d++) begin
            if (m_tvalid[d] && m_tready[d]) begin
              if (d == 0) obs_a.push_back({m_tid[d], m_tuser[d], m_tlast[d], m_tdata[d]});
              else        obs_b.push_back({m_tid[d], m_tuser[d], m_tlast[d], m_tdata[d]});
            end
            if (stall[d])
              chk($sformatf("stall_hold d%0d", d),
                  32'({m_tvalid[d], m_tid[d], m_tuser[d], m_tlast[d], m_tdata[d]}), 32'(held[d]));
            stall[d] = m_tvalid[d] && !m_tready[d] && !rst[d];
            held[d]  = {m_tvalid[d], m_tid[d], m_tuser[d], m_tlast[d], m_tdata[d]};
            chk($sformatf("tready_excl d%0d", d), 32'(s_tready[d][0] && s_tready[d][1]), 32'd0);
          end
          // A byte taken while the output is stalled fills the skid: ready must drop.
          if (fill) chk("tready_full", 32'(s_tready[0][0]), 32'd0);
          fill = s_tvalid[0][0] && s_tready[0][0] && m_tvalid[0] && !m_tready[0] && !rst[0];
        end
      end

      // Directed stimulus.
      begin
        tick(3);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Reset state.
        chk("rst m_tvalid", 32'(m_tvalid[0]), 32'd0);
        chk("rst m_tdata",  32'(m_tdata[0]),  32'd0);
        chk("rst m_tlast",  32'(m_tlast[0]),  32'd0);
        chk("rst m_tid",    32'(m_tid[0]),    32'd0);
        chk("rst m_tuser",  32'(m_tuser[0]),  32'd0);
        chk("rst s0_tready", 32'(s_tready[0][0]), 32'd0);
        chk("rst s1_tready", 32'(s_tready[0][1]), 32'd0);
        chk("rst fc0", 32'(fc0[0]), 32'd0);
        chk("rst fc1", 32'(fc1[0]), 32'd0);
        chk("rst tc",  32'(tc[0]),  32'd0);

        // Single 4-byte frame on input 0, first output beat two edges after tvalid.
        mark = obs_a.size();
        add_frame(1'b0, 8'hA1, 4, 1500);
        fork
          send(0, 0, 8'hA1, 4);
          begin
            chk("single idle_ready", 32'(s_tready[0][0]), 32'd0);
            @(posedge clk); #2;
            chk("single tvalid_e1", 32'(m_tvalid[0]), 32'd0);
            chk("single ready_e1",  32'(s_tready[0][0]), 32'd1);
            @(posedge clk); #2;
            chk("single tvalid_e2", 32'(m_tvalid[0]), 32'd1);
            chk("single tdata_e2",  32'(m_tdata[0]), 32'hA1);
          end
        join
        tick(3);
        cmp_frames("single", 0, mark);
        chk("single fc0", 32'(fc0[0]), 32'd1);
        chk("single fc1", 32'(fc1[0]), 32'd0);

        // Round-robin with both inputs continuously loaded.
        do_reset(0);
        chk("rr rst fc0", 32'(fc0[0]), 32'd0);
        mark = obs_a.size();
        add_frame(1'b0, 8'h10, 3, 1500);
        add_frame(1'b1, 8'h20, 3, 1500);
        add_frame(1'b0, 8'h13, 3, 1500);
        add_frame(1'b1, 8'h23, 3, 1500);
        fork
          begin send(0, 0, 8'h10, 3); send(0, 0, 8'h13, 3); end
          begin send(0, 1, 8'h20, 3); send(0, 1, 8'h23, 3); end
        join
        tick(3);
        cmp_frames("rr", 0, mark);
        chk("rr fc0", 32'(fc0[0]), 32'd2);
        chk("rr fc1", 32'(fc1[0]), 32'd2);

        // Fixed priority: input 1 waits until input 0 stops offering frames.
        mark = obs_b.size();
        add_frame(1'b0, 8'h30, 3, 8);
        add_frame(1'b0, 8'h33, 3, 8);
        add_frame(1'b1, 8'h40, 3, 8);
        add_frame(1'b1, 8'h43, 3, 8);
        fork
          begin send(1, 0, 8'h30, 3); send(1, 0, 8'h33, 3); end
          begin send(1, 1, 8'h40, 3); send(1, 1, 8'h43, 3); end
        join
        tick(3);
        cmp_frames("fp", 1, mark);
        chk("fp fc0", 32'(fc0[1]), 32'd2);
        chk("fp fc1", 32'(fc1[1]), 32'd2);
        chk("fp tc",  32'(tc[1]),  32'd0);

        // Truncation at MAX_LEN=8, then an exact 8-byte frame.
        do_reset(1);
        mark = obs_b.size();
        add_frame(1'b1, 8'h00, 12, 8);
        add_frame(1'b1, 8'h50, 8, 8);
        send(1, 1, 8'h00, 12);
        chk("trunc tc",  32'(tc[1]),  32'd1);
        chk("trunc fc1", 32'(fc1[1]), 32'd0);
        send(1, 1, 8'h50, 8);
        tick(3);
        cmp_frames("trunc", 1, mark);
        chk("exact fc1", 32'(fc1[1]), 32'd1);
        chk("exact tc",  32'(tc[1]),  32'd1);

        // Backpressure 1,0,0,1,0,1 repeating over a 10-byte frame.
        do_reset(0);
        mark = obs_a.size();
        add_frame(1'b0, 8'h60, 10, 1500);
        pat = 6'b101001;
        fork
          send(0, 0, 8'h60, 10);
          begin
            for (int c = 0; c < 40; c++) begin
              m_tready[0] = pat[c % 6];
              tick(1);
            end
            m_tready[0] = 1'b1;
          end
        join
        tick(3);
        cmp_frames("bp", 0, mark);
        chk("bp fc0", 32'(fc0[0]), 32'd1);

        // Reset while byte 3 of a 6-byte frame is offered.
        s_tvalid[0][0] = 1'b1;
        s_tdata[0][0]  = 8'h70;
        s_tlast[0][0]  = 1'b0;
        tick(1);
        chk("rmid granted", 32'(s_tready[0][0]), 32'd1);
        tick(1);
        s_tdata[0][0] = 8'h71;
        tick(1);
        s_tdata[0][0] = 8'h72;
        rst[0] = 1'b1;
        tick(1);
        rst[0] = 1'b0;
        s_tvalid[0][0] = 1'b0;
        s_tdata[0][0]  = 8'h00;
        chk("rmid m_tvalid",  32'(m_tvalid[0]), 32'd0);
        chk("rmid s0_tready", 32'(s_tready[0][0]), 32'd0);
        chk("rmid s1_tready", 32'(s_tready[0][1]), 32'd0);
        chk("rmid fc0", 32'(fc0[0]), 32'd0);
        chk("rmid fc1", 32'(fc1[0]), 32'd0);
        chk("rmid tc",  32'(tc[0]),  32'd0);
        mark = obs_a.size();
        add_frame(1'b1, 8'h80, 2, 1500);
        send(0, 1, 8'h80, 2);
        tick(3);
        cmp_frames("rmid", 0, mark);
        chk("rmid new fc1", 32'(fc1[0]), 32'd1);

        done = 1'b1;
      end
    join

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
